memory_recorder: RTL and testbench
==================================

MEMORY_RECORDER -- requirements
Module: memory_recorder

Interface
REQ-001 Parameter TICK_CYCLES, default 50000000, SHALL set the clock cycles between captured samples (1 s at 50 MHz).
REQ-002 Parameter DATA_W, default 32, SHALL set the sample width.
REQ-003 Parameter DEPTH, default 256, SHALL set the number of storage words; ADDR_W = 8.
REQ-004 clk  input  1  SHALL be the single rising-edge clock.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL be a one-cycle pulse that begins a new recording.
REQ-007 stop  input  1  SHALL be a one-cycle pulse that ends the recording in progress.
REQ-008 clear  input  1  SHALL be a one-cycle pulse that discards the recorded length.
REQ-009 data_in  input  DATA_W  SHALL be the value sampled at each tick.
REQ-010 rd_addr  input  ADDR_W  SHALL be the playback read address.
REQ-011 rd_data  output  DATA_W  SHALL be the registered read data for rd_addr.
REQ-012 length  output  ADDR_W+1  SHALL be the number of valid words recorded (0..DEPTH).
REQ-013 recording  output  1  SHALL be high while in state REC.
REQ-014 full  output  1  SHALL be high while in state FULL.

Function
REQ-015 The FSM SHALL have the states IDLE, REC and FULL.
REQ-016 In IDLE or FULL, start SHALL zero length, the write pointer and the tick counter, then enter REC on the next cycle.
REQ-017 In REC, start SHALL be ignored.
REQ-018 In REC, the tick counter SHALL count 0..TICK_CYCLES-1 and wrap.
REQ-019 At terminal count, data_in SHALL be written to mem[write pointer], and the pointer and length SHALL each increment by 1.
REQ-020 The first write SHALL occur TICK_CYCLES cycles after REC is entered.
REQ-021 The write that makes length reach DEPTH SHALL move the FSM to FULL on the same edge; no further writes SHALL occur.
REQ-022 stop in REC SHALL return the FSM to IDLE and preserve length and memory contents.
REQ-023 A write due on the same cycle as stop SHALL still complete.
REQ-024 clear in any state SHALL zero length, the pointer and the counter and enter IDLE; memory contents SHALL be untouched.
REQ-025 Priority SHALL be clear > stop > start.
REQ-026 rd_data SHALL equal mem[rd_addr] one cycle after rd_addr is applied, in every state.
REQ-027 A read and write to the same address in the same cycle SHALL return the old data.
REQ-028 Reads at addresses >= length SHALL return stale contents without error.

Reset
REQ-029 Asserting rst low SHALL immediately force state IDLE, length 0, pointer 0, counter 0, recording 0, full 0 and rd_data 0.
REQ-030 Reset SHALL NOT initialise memory, so the array maps to block RAM.
REQ-031 Reset asserted mid-recording SHALL abort without completing any pending write.

Structure
REQ-032 Package recorder_pkg SHALL hold the state enum, DATA_W, ADDR_W and DEPTH.
REQ-033 A sub-module tick_gen SHALL contain the TICK_CYCLES counter (inputs: enable, sync clear; output: one-cycle tick pulse).
REQ-034 The counter width SHALL be $clog2(TICK_CYCLES).
REQ-035 The memory SHALL be inferred in memory_recorder with one write port and one registered read port.

Verification (TICK_CYCLES=4 for simulation)
REQ-036 Scenario: reset, start, data_in=0xA5 held for 4 cycles -> mem[0]=0xA5 and length=1 four cycles after REC entry; rd_addr=0 gives rd_data=0xA5 one cycle later.
REQ-037 Scenario: start, then stop after 10 cycles -> 2 writes, length=2, state IDLE, recording=0.
REQ-038 Scenario: start with data_in=index, run 1024+ cycles -> length=256, full=1, mem[255]=255, no write at pointer wrap.
REQ-039 Scenario: stop and tick on the same cycle -> the write lands; length increments, then IDLE.
REQ-040 Scenario: start and clear in the same cycle from FULL -> IDLE, length=0, previous memory intact.
REQ-041 Scenario: rst low mid-REC, one cycle before a tick -> no write, all outputs 0; start after release records from address 0.

Source files
------------

// File: rtl/recorder_pkg.sv
// Shared types and sizing for the memory recorder.
package recorder_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        FULL = 2'd2
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running sample tick divider: one-cycle pulse every TICK_CYCLES enabled cycles.
module tick_gen #(
    parameter int TICK_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sclr,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count 0..TICK_CYCLES-1 while enabled, wrap at terminal count; sclr restarts from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (sclr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (cnt_r == TERM) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Terminal-count decode of the registered counter.
    assign tick = en && (cnt_r == TERM);

endmodule

// File: rtl/memory_recorder.sv
// Periodic sample recorder: captures data_in once per tick into a RAM
// with a registered playback read port.
module memory_recorder
    import recorder_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000,
    parameter int DATA_W      = recorder_pkg::DATA_W,
    parameter int DEPTH       = recorder_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   length,
    output logic              recording,
    output logic              full
);

    localparam int LEN_W = ADDR_W + 1;

    state_e            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [LEN_W-1:0]  len_r;
    logic              rec_r;
    logic              full_r;
    logic [DATA_W-1:0] rd_data_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic tick_s;
    logic tick_en_s;
    logic tick_clr_s;
    logic start_ok_s;
    logic wr_en_s;
    logic last_s;

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en_s),
        .sclr (tick_clr_s),
        .tick (tick_s)
    );

    // Decode accepted commands and write strobe; clear outranks stop, stop outranks start.
    always_comb begin
        start_ok_s = 1'b0;
        wr_en_s    = 1'b0;
        if (clear) begin
            start_ok_s = 1'b0;
            wr_en_s    = 1'b0;
        end else begin
            case (state_r)
                IDLE, FULL: begin
                    start_ok_s = start && !stop;
                    wr_en_s    = 1'b0;
                end
                REC: begin
                    start_ok_s = 1'b0;
                    wr_en_s    = tick_s;
                end
                default: begin
                    start_ok_s = 1'b0;
                    wr_en_s    = 1'b0;
                end
            endcase
        end
    end

    assign tick_en_s  = (state_r == REC);
    assign tick_clr_s = clear || start_ok_s;
    assign last_s     = (len_r == LEN_W'(DEPTH - 1));

    // Recording state machine with registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            ptr_r   <= {ADDR_W{1'b0}};
            len_r   <= {LEN_W{1'b0}};
            rec_r   <= 1'b0;
            full_r  <= 1'b0;
        end else if (clear) begin
            state_r <= IDLE;
            ptr_r   <= {ADDR_W{1'b0}};
            len_r   <= {LEN_W{1'b0}};
            rec_r   <= 1'b0;
            full_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, FULL: begin
                    if (start_ok_s) begin
                        state_r <= REC;
                        ptr_r   <= {ADDR_W{1'b0}};
                        len_r   <= {LEN_W{1'b0}};
                        rec_r   <= 1'b1;
                        full_r  <= 1'b0;
                    end
                end
                REC: begin
                    // A write due alongside stop still completes.
                    if (wr_en_s) begin
                        ptr_r <= ptr_r + ADDR_W'(1);
                        len_r <= len_r + LEN_W'(1);
                    end
                    if (stop) begin
                        state_r <= IDLE;
                        rec_r   <= 1'b0;
                        full_r  <= 1'b0;
                    end else if (wr_en_s && last_s) begin
                        state_r <= FULL;
                        rec_r   <= 1'b0;
                        full_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    rec_r   <= 1'b0;
                    full_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sample write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[ptr_r] <= data_in;
        end
    end

    // Registered read port; same-address read during write returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data   = rd_data_r;
    assign length    = len_r;
    assign recording = rec_r;
    assign full      = full_r;

endmodule

// File: tb/tb_memory_recorder.sv
// Self-checking bench for memory_recorder with a cycle-level reference model
// and a read-data scoreboard.
module tb_memory_recorder;

    localparam int TC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        clear;
    logic [31:0] data_in;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [8:0]  length;
    logic        recording;
    logic        full;

    always #5 clk = ~clk;

    memory_recorder #(
        .TICK_CYCLES(TC),
        .DATA_W     (32),
        .DEPTH      (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .data_in   (data_in),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .length    (length),
        .recording (recording),
        .full      (full)
    );

    typedef struct {
        bit          chk;
        logic [31:0] val;
        logic [7:0]  addr;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_mem [256];
    bit          m_vld [256];
    int          m_state;   // 0 idle, 1 rec, 2 full
    int          m_len;
    int          m_ptr;
    int          m_cnt;
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance model, push expected read, then compare after the edge.
    task automatic step(input bit s, input bit p, input bit c, input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        bit   tk;
        start   = s;
        stop    = p;
        clear   = c;
        rd_addr = a;
        data_in = d;
        e.chk = m_vld[a];
        e.val = m_mem[a];
        e.addr = a;
        sb_q.push_back(e);
        tk = (m_state == 1) && (m_cnt == TC - 1);
        if (c) begin
            m_state = 0; m_len = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_state == 1) begin
            if (tk) begin
                m_mem[m_ptr] = d;
                m_vld[m_ptr] = 1'b1;
                m_ptr = (m_ptr + 1) % 256;
                m_len++;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            if (p) m_state = 0;
            else if (m_len == 256) m_state = 2;
        end else if (s && !p) begin
            m_state = 1; m_len = 0; m_ptr = 0; m_cnt = 0;
        end
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (e.chk) check_eq($sformatf("rd_data[%0d]", e.addr), rd_data, e.val);
        check_eq("length", {23'd0, length}, 32'(m_len));
        check_eq("recording", {31'd0, recording}, {31'd0, (m_state == 1)});
        check_eq("full", {31'd0, full}, {31'd0, (m_state == 2)});
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        data_in = 32'd0; rd_addr = 8'd0;
        for (int i = 0; i < 256; i++) begin
            m_vld[i] = 1'b0;
            m_mem[i] = 32'd0;
        end
        m_state = 0; m_len = 0; m_ptr = 0; m_cnt = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_length", {23'd0, length}, 32'd0);
        check_eq("rst_recording", {31'd0, recording}, 32'd0);
        check_eq("rst_full", {31'd0, full}, 32'd0);
        check_eq("rst_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // First capture lands TICK_CYCLES after REC entry
        step(1'b1, 1'b0, 1'b0, 8'd0, 32'hA5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 32'hA5);
        check_eq("s1_len_before_tick", {23'd0, length}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0, 32'hA5);
        check_eq("s1_len", {23'd0, length}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'd0, 32'hA5);
        check_eq("s1_rd", rd_data, 32'hA5);
        step(1'b0, 1'b1, 1'b0, 8'd0, 32'h0);

        // Stop after 10 cycles: two captures
        step(1'b1, 1'b0, 1'b0, 8'd0, 32'h11);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 8'd1, 32'h11 + 32'(i));
        step(1'b0, 1'b1, 1'b0, 8'd1, 32'h55);
        check_eq("s2_len", {23'd0, length}, 32'd2);
        check_eq("s2_rec", {31'd0, recording}, 32'd0);

        // Stop on the tick cycle: write still lands
        step(1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 8'd0, 32'h77);
        check_eq("s3_len", {23'd0, length}, 32'd1);
        check_eq("s3_rec", {31'd0, recording}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
        check_eq("s3_rd", rd_data, 32'h77);

        // Fill to DEPTH with data = index; no write after the pointer wraps
        step(1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
        for (int i = 0; i < 1030; i++) step(1'b0, 1'b0, 1'b0, 8'(i), 32'(m_ptr));
        check_eq("s4_len", {23'd0, length}, 32'd256);
        check_eq("s4_full", {31'd0, full}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'd255, 32'hFFFF);
        check_eq("s4_rd255", rd_data, 32'd255);
        step(1'b0, 1'b0, 1'b0, 8'd0, 32'hFFFF);
        check_eq("s4_rd0", rd_data, 32'd0);

        // start + clear together from FULL: clear wins, memory kept
        step(1'b1, 1'b0, 1'b1, 8'd10, 32'h0);
        check_eq("s5_len", {23'd0, length}, 32'd0);
        check_eq("s5_full", {31'd0, full}, 32'd0);
        check_eq("s5_rec", {31'd0, recording}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'd10, 32'h0);
        check_eq("s5_rd10", rd_data, 32'd10);

        // Reset one cycle before a tick: pending write aborted
        step(1'b0, 1'b0, 1'b0, 8'd5, 32'h0);
        step(1'b1, 1'b0, 1'b0, 8'd5, 32'hDEAD);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd5, 32'hDEAD);
        data_in = 32'hDEAD;
        rst = 1'b0;
        #1;
        check_eq("s6_rst_len", {23'd0, length}, 32'd0);
        check_eq("s6_rst_rec", {31'd0, recording}, 32'd0);
        check_eq("s6_rst_full", {31'd0, full}, 32'd0);
        check_eq("s6_rst_rd", rd_data, 32'd0);
        m_state = 0; m_len = 0; m_ptr = 0; m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'd5, 32'h0);
        check_eq("s6_rd5", rd_data, 32'd5);
        step(1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
        check_eq("s6_nowrite", rd_data, 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0, 32'hBEEF);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 32'hBEEF);
        check_eq("s6_len", {23'd0, length}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
        check_eq("s6_rd0", rd_data, 32'hBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
